// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - RS wakeup/select controller with per-FU rotating-priority issue
//
// Tracks busy/fu/tags/ready bits per RS slot, snoops result-broadcast tags,
// and picks at most one eligible slot per functional unit each cycle.
// Optional build macro: RS_SCHED_PERF_EN adds perf_issue_cnt / perf_stall_cnt.
//
// Ports:
//   clk, reset (sync, active-low)
//   alloc_*        : dispatch writes one entry per cycle into alloc_slot
//   wake_valid/tag : per-FU result tag broadcast (FU k at tag bits [6k+5:6k])
//   flush          : discard all entries
//   issue_ready    : per-FU accept; issue_valid/issue_slot per-FU selection
//   busy_bitmap, free_count, alloc_ready, alloc_err : occupancy and error status
module rs_issue_scheduler #(
    parameter int RS_SIZE = 64,
    parameter int TAG_W   = 6,
    parameter int NUM_FU  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    input  logic [$clog2(RS_SIZE)-1:0]        alloc_slot,
    input  logic [1:0]                        alloc_fu,
    input  logic [TAG_W-1:0]                  alloc_rs1_tag,
    input  logic [TAG_W-1:0]                  alloc_rs2_tag,
    input  logic                              alloc_rs1_ready,
    input  logic                              alloc_rs2_ready,
    input  logic [NUM_FU-1:0]                 wake_valid,
    input  logic [NUM_FU*TAG_W-1:0]           wake_tag,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 issue_ready,
    output logic [NUM_FU-1:0]                 issue_valid,
    output logic [NUM_FU*$clog2(RS_SIZE)-1:0] issue_slot,
    output logic [RS_SIZE-1:0]                busy_bitmap,
    output logic [$clog2(RS_SIZE):0]          free_count,
    output logic                              alloc_ready,
`ifdef RS_SCHED_PERF_EN
    output logic [NUM_FU*32-1:0]              perf_issue_cnt,
    output logic [31:0]                       perf_stall_cnt,
`endif
    output logic                              alloc_err
);
    localparam int SLOT_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy, rdy1, rdy2;
    logic [1:0]         fu_q   [RS_SIZE];
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];
    logic [SLOT_W-1:0]  rr_ptr [NUM_FU];
    // Last cycle's unfired selection; keeps issue_slot stable while the FU stalls.
    logic [NUM_FU-1:0]  held_valid;
    logic [SLOT_W-1:0]  held_slot [NUM_FU];
    logic [SLOT_W:0]    free_q;
    logic               err_q;

    logic [RS_SIZE-1:0] elig [NUM_FU];
    logic [SLOT_W-1:0]  sel_slot [NUM_FU];
    logic [NUM_FU-1:0]  sel_valid;
    logic [SLOT_W-1:0]  idx;
    logic [NUM_FU-1:0]  fire;
    logic               fire_hits_alloc, byp1, byp2, alloc_ok, alloc_bad;
    logic [SLOT_W:0]    free_next;

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            for (int s = 0; s < RS_SIZE; s++) begin
                elig[k][s] = busy[s] & rdy1[s] & rdy2[s] & (fu_q[s] == 2'(k));
            end
        end
    end

    always_comb begin
        idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sel_valid[k] = 1'b0;
            sel_slot[k]  = '0;
            if (held_valid[k] && elig[k][held_slot[k]]) begin
                sel_valid[k] = 1'b1;
                sel_slot[k]  = held_slot[k];
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    idx = rr_ptr[k] + SLOT_W'(i);
                    if (!sel_valid[k] && elig[k][idx]) begin
                        sel_valid[k] = 1'b1;
                        sel_slot[k]  = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        fire_hits_alloc = 1'b0;
        byp1 = 1'b0;
        byp2 = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            issue_valid[k] = sel_valid[k];
            issue_slot[SLOT_W*k +: SLOT_W] = sel_slot[k];
            fire[k] = sel_valid[k] & issue_ready[k];
            if (fire[k] && sel_slot[k] == alloc_slot) fire_hits_alloc = 1'b1;
            if (wake_valid[k] && wake_tag[TAG_W*k +: TAG_W] == alloc_rs1_tag) byp1 = 1'b1;
            if (wake_valid[k] && wake_tag[TAG_W*k +: TAG_W] == alloc_rs2_tag) byp2 = 1'b1;
        end
        // A slot firing this edge is already free for a same-cycle alloc.
        alloc_ok  = alloc_valid & (alloc_fu != 2'd3) & (~busy[alloc_slot] | fire_hits_alloc);
        alloc_bad = alloc_valid & ((alloc_fu == 2'd3) | (busy[alloc_slot] & ~fire_hits_alloc));
        free_next = free_q - (SLOT_W+1)'(alloc_ok);
        for (int k = 0; k < NUM_FU; k++) free_next = free_next + (SLOT_W+1)'(fire[k]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy       <= '0;
            rdy1       <= '0;
            rdy2       <= '0;
            held_valid <= '0;
            free_q     <= (SLOT_W+1)'(RS_SIZE);
            err_q      <= 1'b0;
            for (int k = 0; k < NUM_FU; k++) begin
                rr_ptr[k]    <= '0;
                held_slot[k] <= '0;
            end
        end else if (flush) begin
            busy       <= '0;
            rdy1       <= '0;
            rdy2       <= '0;
            held_valid <= '0;
            free_q     <= (SLOT_W+1)'(RS_SIZE);
            for (int k = 0; k < NUM_FU; k++) begin
                rr_ptr[k]    <= '0;
                held_slot[k] <= '0;
            end
        end else begin
            for (int s = 0; s < RS_SIZE; s++) begin
                for (int k = 0; k < NUM_FU; k++) begin
                    if (wake_valid[k] && busy[s] && tag1_q[s] == wake_tag[TAG_W*k +: TAG_W]) rdy1[s] <= 1'b1;
                    if (wake_valid[k] && busy[s] && tag2_q[s] == wake_tag[TAG_W*k +: TAG_W]) rdy2[s] <= 1'b1;
                end
            end
            for (int k = 0; k < NUM_FU; k++) begin
                if (fire[k]) begin
                    busy[sel_slot[k]] <= 1'b0;
                    rr_ptr[k]         <= sel_slot[k] + 1'b1;
                end
                held_valid[k] <= sel_valid[k] & ~fire[k];
                held_slot[k]  <= sel_slot[k];
            end
            // Written after the fire clear so a same-cycle re-alloc wins.
            if (alloc_ok) begin
                busy[alloc_slot]   <= 1'b1;
                fu_q[alloc_slot]   <= alloc_fu;
                tag1_q[alloc_slot] <= alloc_rs1_tag;
                tag2_q[alloc_slot] <= alloc_rs2_tag;
                rdy1[alloc_slot]   <= alloc_rs1_ready | byp1;
                rdy2[alloc_slot]   <= alloc_rs2_ready | byp2;
            end
            if (alloc_bad) err_q <= 1'b1;
            free_q <= free_next;
        end
    end

    assign busy_bitmap = busy;
    assign free_count  = free_q;
    assign alloc_ready = (free_q != '0);
    assign alloc_err   = err_q;

`ifdef RS_SCHED_PERF_EN
    logic [31:0] issue_cnt_q [NUM_FU];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            for (int k = 0; k < NUM_FU; k++) issue_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) issue_cnt_q[k] <= issue_cnt_q[k] + 32'(fire[k]);
            if ((|busy) && sel_valid == '0) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) perf_issue_cnt[32*k +: 32] = issue_cnt_q[k];
    end
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Wakeup/select controller for the 64-entry reservation station. Tracks operand tags and ready bits per RS slot, snoops up to three result-broadcast tags per cycle, and selects at most one ready entry per functional unit (FU0..FU2) each cycle with rotating priority. The RS datapath holds operand values and immediates; this block only decides which slot issues and when that slot is freed.

Parameters:
RS_SIZE, 64, number of RS slots (power of two; slot index width 6)
TAG_W, 6, physical register tag width
NUM_FU, 3, number of functional units (fixed at 3; per-FU ports are flattened)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
alloc_valid  in  1  dispatch writes a new entry this cycle
alloc_slot  in  6  target slot (chosen by RS free-slot finder)
alloc_fu  in  2  target FU 0..2; value 3 is illegal
alloc_rs1_tag, alloc_rs2_tag  in  6 each  source physical tags
alloc_rs1_ready, alloc_rs2_ready  in  1 each  source already available
wake_valid  in  3  per-FU result broadcast valid
wake_tag  in  18  per-FU broadcast tag, FU k at [6k+5:6k]
flush  in  1  discard all entries (mispredict)
issue_ready  in  3  FU k accepts an issue this cycle
issue_valid  out  3  FU k has a selected slot
issue_slot  out  18  selected slot for FU k at [6k+5:6k]
busy_bitmap  out  64  registered occupancy per slot
free_count  out  7  registered count of non-busy slots
alloc_ready  out  1  free_count != 0
alloc_err  out  1  sticky: alloc to busy slot or alloc_fu==3

Behaviour:
- Per-slot state: busy, fu[1:0], tag1, rdy1, tag2, rdy2.
- Reset (reset==0 at edge): all busy/rdy cleared, rr_ptr[k]=0, alloc_err=0, free_count=64, alloc_ready=1; issue_valid=0 following.
- Wakeup: for each k with wake_valid[k], every busy slot with tagX==wake_tag_k sets rdyX at the edge. Multiple matches in one cycle are all set.
- Alloc bypass: when alloc_rsX_tag matches any valid wake_tag in the same cycle, rdyX is stored as 1 regardless of alloc_rsX_ready.
- Eligible(slot,k) = busy & rdy1 & rdy2 & fu==k.
- Select: combinational from registered state. For FU k, scan starting at rr_ptr[k] upward, wrapping 63->0; first eligible slot drives issue_slot_k and issue_valid[k]=1. No eligible slot gives issue_valid[k]=0 and issue_slot_k=0. An operand woken at edge N is issuable in cycle N (one-cycle wakeup-to-select).
- Fire: issue_valid[k] & issue_ready[k]. At the edge, the slot's busy bit is cleared and rr_ptr[k] is set to slot+1 mod 64. Without fire, issue_slot_k is held stable for as long as it remains eligible and no flush occurs.
- A slot has exactly one fu, so the three FUs never select the same slot.
- Alloc into a busy slot: ignored and alloc_err set. Exception: a slot firing in the same cycle is free, so the alloc is accepted and the new entry wins.
- alloc_fu==3: ignored, alloc_err set.
- free_count and busy_bitmap update at the same edge as alloc or fire. Full: alloc_ready=0; an alloc while full is an alloc-to-busy error.
- flush (priority below reset, above alloc/fire): clears all busy/rdy bits and rr_ptr; a same-cycle alloc is dropped. alloc_err is not cleared.

Optional Feature:
RS_SCHED_PERF_EN: adds output perf_issue_cnt (96 bits, 32-bit per-FU count of fires) and perf_stall_cnt (32 bits, cycles with at least one busy slot and issue_valid==0). Counters wrap, are cleared by reset only (not by flush), and update at the edge.
Without the macro: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then alloc slot 5 with fu=1 and both operands ready -> next cycle issue_valid=3'b010, issue_slot_1=5; with issue_ready[1]=1 -> busy_bitmap[5]=0 and free_count=64.
- Alloc slot 9 with fu=0, rs1_tag=12 not ready; 3 cycles later wake_valid[2] with tag 12 -> issue_valid[0] rises exactly the cycle after the wake edge, issue_slot_0=9.
- Alloc with rs2_tag=7 not ready while wake_tag_0=7 is valid in the same cycle -> entry is issuable the next cycle (bypass).
- Fill slots 62, 63, 0 with ready fu=2 entries, rr_ptr[2] at 62 -> issue order is 62, 63, 0 (wrap-around), with issue_ready[2] held at 1.
- Alloc to busy slot 3 -> alloc_err=1 and the entry is unchanged. Alloc to slot 3 in the same cycle slot 3 fires -> accepted, alloc_err unchanged.
- 10 entries busy, flush asserted with a simultaneous alloc -> free_count=64, issue_valid=0, and no entry for the dropped alloc. Then reset low mid-stream -> all outputs at reset values next cycle.
